regwr_rr_arb: RTL

//  Round-robin write arbiter for a bank of 2**AW enabled 16-bit registers.
//  Two requesters compete for the single shared write port of the bank.
//  Per write, the block:
//   - picks one winner, registers its address and data;
//   - drives a one-hot enable and the shared data bus into the bank for one cycle;
//   - pulses an ack back to the winner.

---
 rtl/regwr_rr_arb_if.sv | 46 ++++
 rtl/regwr_rr_arb.sv | 90 +++++++++
 2 files changed

// File: rtl/regwr_rr_arb_if.sv
// Purpose: bundle the two requester write channels and the bank-side write
//          port of the round-robin register-write arbiter.
// Signals:
//   req0/addr0/data0 -> ack0   requester 0 write channel
//   req1/addr1/data1 -> ack1   requester 1 write channel
//   wr_en[NREG]/wr_data        one-hot enable and shared data into the bank
//   busy                       arbiter is in its write cycle
// Modports:
//   master - requester/bank side (drives requests, observes acks and bank port)
//   slave  - arbiter side
interface regwr_rr_arb_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
);

  localparam int unsigned NREG = 1 << AW;

  logic             req0;
  logic [AW-1:0]    addr0;
  logic [WIDTH-1:0] data0;
  logic             ack0;

  logic             req1;
  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] data1;
  logic             ack1;

  logic [NREG-1:0]  wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             busy;

  modport master (
    output req0, addr0, data0,
    output req1, addr1, data1,
    input  ack0, ack1,
    input  wr_en, wr_data, busy
  );

  modport slave (
    input  req0, addr0, data0,
    input  req1, addr1, data1,
    output ack0, ack1,
    output wr_en, wr_data, busy
  );

endinterface

// File: rtl/regwr_rr_arb.sv
// Purpose: round-robin arbiter granting one of two requesters the single
//          write port of a bank of 2**AW registers. Each grant produces one
//          WRITE cycle with a one-hot enable, the winner's data and an ack.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - regwr_rr_arb_if.slave: req/addr/data in, ack/wr_en/wr_data/busy out
// All outputs come straight from flops.
module regwr_rr_arb #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  regwr_rr_arb_if.slave  bus
);

  localparam int unsigned NREG = 1 << AW;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t           state;
  logic             last;      // id of the most recent completed grant
  logic [NREG-1:0]  wr_en_q;
  logic [WIDTH-1:0] wr_data_q;
  logic             ack0_q;
  logic             ack1_q;
  logic             busy_q;
  logic             grant1_c;

  // Requester 1 wins if alone, or on a tie when requester 0 went last.
  always_comb begin
    grant1_c = bus.req1 & (~bus.req0 | ~last);
  end

  // Arbitration FSM. The winner's address and data are captured directly
  // into the registered enable/data outputs, and the ack flops double as
  // the captured winner id used to update the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            state  <= WRITE;
            busy_q <= 1'b1;
            if (grant1_c) begin
              wr_en_q   <= NREG'(1) << bus.addr1;
              wr_data_q <= bus.data1;
              ack1_q    <= 1'b1;
            end else begin
              wr_en_q   <= NREG'(1) << bus.addr0;
              wr_data_q <= bus.data0;
              ack0_q    <= 1'b1;
            end
          end
        end
        WRITE: begin
          // Single write cycle; requests are ignored here.
          state   <= IDLE;
          last    <= ack1_q;
          wr_en_q <= '0;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_data = wr_data_q;
  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.busy    = busy_q;

endmodule
